// File: rtl/dcp_print_fmt.sv
// dcp_print_fmt: DCP console transmit formatter (raw char or hex word).
// Optional DCP_PRINT_LZS_EN: suppress leading zeros of hex words.
module dcp_print_fmt #(
  parameter bit UPPER = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] dout_tx,
  output logic        ack_tx,
  output logic        vld_tx,
  output logic [7:0]  d_tx,
  input  logic        rdy_tx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Offset so that nibble 10 lands on 'A' (0x41) or 'a' (0x61).
  localparam logic [7:0] ALPHA = UPPER ? 8'h37 : 8'h57;

  state_t      state;
  state_t      state_nx;
  logic [31:0] sreg;
  logic [31:0] sreg_nx;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nx;
  logic        vld_nx;
  logic [7:0]  d_nx;
  logic        ack_nx;
  logic        xfer;

  logic [31:0] cap_sreg;
  logic [2:0]  cap_cnt;

  function automatic logic [7:0] hex_ascii(
    input logic [3:0] n
  );
    if (n < 4'd10) begin
      return {4'h3, n};
    end
    return ALPHA + {4'h0, n};
  endfunction

  assign xfer = vld_tx & rdy_tx;

`ifdef DCP_PRINT_LZS_EN
  logic [2:0] lz;

  // Count leading zero nibbles; zero word keeps one '0' digit.
  always_comb begin
    lz = 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (dout_tx[4*i +: 4] != 4'h0) begin
        lz = 3'(7 - i);
      end
    end
  end

  assign cap_sreg = dout_tx << {lz, 2'b00};
  assign cap_cnt  = 3'd7 - lz;
`else
  assign cap_sreg = dout_tx;
  assign cap_cnt  = 3'd7;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_tx) begin
          state_nx = SEND;
        end
      end
      SEND: begin
        if (xfer && cnt == 3'd0) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    sreg_nx = sreg;
    cnt_nx  = cnt;
    vld_nx  = vld_tx;
    d_nx    = d_tx;
    ack_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        vld_nx = 1'b0;
        if (req_tx) begin
          vld_nx = 1'b1;
          if (type_tx) begin
            sreg_nx = cap_sreg;
            cnt_nx  = cap_cnt;
            d_nx    = hex_ascii(cap_sreg[31:28]);
          end else begin
            sreg_nx = dout_tx;
            cnt_nx  = 3'd0;
            d_nx    = dout_tx[7:0];
          end
        end
      end
      SEND: begin
        if (xfer) begin
          if (cnt != 3'd0) begin
            sreg_nx = sreg << 4;
            cnt_nx  = cnt - 3'd1;
            d_nx    = hex_ascii(sreg[27:24]);
          end else begin
            vld_nx = 1'b0;
            ack_nx = 1'b1;
          end
        end
      end
      DONE: begin
        vld_nx = 1'b0;
      end
      default: begin
        vld_nx = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg   <= 32'h0;
      cnt    <= 3'd0;
      vld_tx <= 1'b0;
      d_tx   <= 8'h00;
      ack_tx <= 1'b0;
    end else begin
      sreg   <= sreg_nx;
      cnt    <= cnt_nx;
      vld_tx <= vld_nx;
      d_tx   <= d_nx;
      ack_tx <= ack_nx;
    end
  end

endmodule

// File: tb/tb_dcp_print_fmt.sv
// tb_dcp_print_fmt: directed bench for dcp_print_fmt.
// Runs upper- and lower-case instances side by side.
module tb_dcp_print_fmt;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_tx;
  logic        type_tx;
  logic [31:0] dout_tx;
  logic        rdy_tx;
  logic        ack_tx;
  logic        vld_tx;
  logic [7:0]  d_tx;
  logic        ack_l;
  logic        vld_l;
  logic [7:0]  d_l;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dcp_print_fmt #(.UPPER(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_tx  (req_tx),
    .type_tx (type_tx),
    .dout_tx (dout_tx),
    .ack_tx  (ack_tx),
    .vld_tx  (vld_tx),
    .d_tx    (d_tx),
    .rdy_tx  (rdy_tx)
  );

  dcp_print_fmt #(.UPPER(1'b0)) dut_l (
    .clk     (clk),
    .rst     (rst),
    .req_tx  (req_tx),
    .type_tx (type_tx),
    .dout_tx (dout_tx),
    .ack_tx  (ack_l),
    .vld_tx  (vld_l),
    .d_tx    (d_l),
    .rdy_tx  (rdy_tx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lc(
    input logic [7:0] b
  );
    if (b >= 8'h41 && b <= 8'h46) begin
      return b + 8'h20;
    end
    return b;
  endfunction

  // exp holds the expected bytes left-aligned, first byte in [63:56].
  task automatic run_req(
    input logic        t,
    input logic [31:0] d,
    input int          n,
    input logic [63:0] exp,
    input int          stall_at,
    input int          stall_len,
    input int          inj_at,
    input int          abort_at
  );
    logic [7:0] b;
    req_tx  = 1'b1;
    type_tx = t;
    dout_tx = d;
    tick();
    req_tx  = 1'b0;
    type_tx = ~t;
    dout_tx = ~d;
    for (int i = 0; i < n; i++) begin
      b = exp[63-8*i -: 8];
      chk("vld", {31'd0, vld_tx}, 32'd1);
      chk("byte", {24'd0, d_tx}, {24'd0, b});
      chk("byte_lc", {24'd0, d_l},
          {24'd0, t ? lc(b) : b});
      chk("ack_early", {31'd0, ack_tx}, 32'd0);
      if (i == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_vld", {31'd0, vld_tx}, 32'd0);
        chk("abort_ack", {31'd0, ack_tx}, 32'd0);
        chk("abort_d", {24'd0, d_tx}, 32'd0);
        tick();
        chk("abort_vld2", {31'd0, vld_tx}, 32'd0);
        chk("abort_ack2", {31'd0, ack_tx}, 32'd0);
        return;
      end
      if (i == stall_at) begin
        rdy_tx = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk("stall_vld", {31'd0, vld_tx}, 32'd1);
          chk("stall_d", {24'd0, d_tx}, {24'd0, b});
          chk("stall_ack", {31'd0, ack_tx}, 32'd0);
        end
        rdy_tx = 1'b1;
      end
      if (i == inj_at) begin
        req_tx  = 1'b1;
        type_tx = 1'b0;
        dout_tx = 32'h5A;
      end
      tick();
      req_tx = 1'b0;
    end
    chk("end_vld", {31'd0, vld_tx}, 32'd0);
    chk("ack", {31'd0, ack_tx}, 32'd1);
    chk("ack_lc", {31'd0, ack_l}, 32'd1);
    tick();
    chk("ack_pulse", {31'd0, ack_tx}, 32'd0);
    chk("idle_vld", {31'd0, vld_tx}, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    req_tx  = 1'b0;
    type_tx = 1'b0;
    dout_tx = 32'h0;
    rdy_tx  = 1'b1;
    tick();
    tick();
    chk("rst_vld", {31'd0, vld_tx}, 32'd0);
    chk("rst_d", {24'd0, d_tx}, 32'd0);
    chk("rst_ack", {31'd0, ack_tx}, 32'd0);
    rst = 1'b0;
    tick();

    // Raw character.
    run_req(1'b0, 32'h0000_0041, 1,
            64'h4100_0000_0000_0000, -1, 0, -1, -1);
    // Hex word, back-to-back.
    run_req(1'b1, 32'h1234_ABCD, 8,
            64'h3132_3334_4142_4344, -1, 0, -1, -1);
    // Backpressure on the third digit.
    run_req(1'b1, 32'h1234_ABCD, 8,
            64'h3132_3334_4142_4344, 2, 5, -1, -1);
    // Request during SEND is ignored.
    run_req(1'b1, 32'h1234_ABCD, 8,
            64'h3132_3334_4142_4344, -1, 0, 3, -1);
    tick();
    chk("inj_vld", {31'd0, vld_tx}, 32'd0);
    chk("inj_ack", {31'd0, ack_tx}, 32'd0);
    // Reset after the third byte.
    run_req(1'b1, 32'hDEAD_BEEF, 8,
            64'h4445_4144_4245_4546, -1, 0, -1, 3);
`ifdef DCP_PRINT_LZS_EN
    run_req(1'b1, 32'h0000_0007, 1,
            64'h3700_0000_0000_0000, -1, 0, -1, -1);
    run_req(1'b1, 32'h0000_00A5, 2,
            64'h4135_0000_0000_0000, -1, 0, -1, -1);
    run_req(1'b1, 32'h0000_0000, 1,
            64'h3000_0000_0000_0000, -1, 0, -1, -1);
`else
    run_req(1'b1, 32'h0000_0007, 8,
            64'h3030_3030_3030_3037, -1, 0, -1, -1);
    run_req(1'b1, 32'h0000_00A5, 8,
            64'h3030_3030_3030_4135, -1, 0, -1, -1);
    run_req(1'b1, 32'h0000_0000, 8,
            64'h3030_3030_3030_3030, -1, 0, -1, -1);
`endif
    // rdy pulse while idle does nothing.
    rdy_tx = 1'b0;
    tick();
    rdy_tx = 1'b1;
    tick();
    chk("idle_rdy_vld", {31'd0, vld_tx}, 32'd0);
    chk("idle_rdy_ack", {31'd0, ack_tx}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
